// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: shared definitions for the FPU request arbiter.
//   ST_RUN / ST_DRAIN : arbiter FSM state encoding
//   tag_width()       : bits needed to name one of n requesters
//   count_width()     : bits for an occupancy count of 0..depth inclusive
package fpu_arb_pkg;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    function automatic int tag_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fpu_tag_fifo.sv
// fpu_tag_fifo: synchronous FIFO holding the requester tag of every op in
// flight, so results (returned in issue order) can be routed back.
//   clk_i, rst_ni    : clock, async active-low reset (clears pointers/count)
//   push_i, tag_i    : enqueue a tag (ignored when full)
//   pop_i, head_o    : dequeue; head_o is the oldest tag (ignored when empty)
//   full_o, empty_o  : occupancy flags
//   count_o          : occupancy, 0..DEPTH
module fpu_tag_fifo
    import fpu_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TW    = 2,
    localparam int CW = count_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [TW-1:0] tag_i,
    input  logic          pop_i,
    output logic [TW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [TW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= tag_i;
    end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter sharing one in-order FPU among NREQ
// requesters, with at most DEPTH ops in flight.
//   clk_i, rst_ni                 : clock, async active-low reset
//   req_valid_i / req_ready_o     : per-requester request / one-hot accept (comb)
//   req_a_i, req_b_i, req_c_i     : packed operands, requester k at [k*XLEN +: XLEN]
//   rsp_valid_o, rsp_data_o       : one-hot result strobe and shared result data
//   fpu_valid_o, fpu_a/b/c_o      : registered issue strobe and operands to the FPU
//   fpu_result_valid_i/_result_i  : in-order result return from the FPU
//   flush_i                       : stop issuing and drain outstanding ops
//   busy_o                        : ops in flight or draining
//   err_o                         : sticky, set by a result with nothing in flight
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*XLEN-1:0] req_a_i,
    input  logic [NREQ*XLEN-1:0] req_b_i,
    input  logic [NREQ*XLEN-1:0] req_c_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [XLEN-1:0]      rsp_data_o,
    output logic                 fpu_valid_o,
    output logic [XLEN-1:0]      fpu_a_o,
    output logic [XLEN-1:0]      fpu_b_o,
    output logic [XLEN-1:0]      fpu_c_o,
    input  logic                 fpu_result_valid_i,
    input  logic [XLEN-1:0]      fpu_result_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int TW = tag_width(NREQ);
    localparam int CW = count_width(DEPTH);

    logic [0:0]      state;
    logic [TW-1:0]   ptr;
    logic [TW-1:0]   cand;
    logic [TW-1:0]   grant_idx;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic            can_grant;
    logic            pop;
    logic [TW-1:0]   head;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;

    // Uses the registered full flag, so a result popping in the same cycle
    // cannot open a slot for a grant when the FIFO is full.
    assign can_grant = (state == ST_RUN) && !flush_i && !full;
    assign pop       = fpu_result_valid_i && !empty;
    assign busy_o    = (count != '0) || (state == ST_DRAIN);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (can_grant) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = TW'((32'(ptr) + i) % NREQ);
                if (!grant_any && req_valid_i[cand]) begin
                    grant_any   = 1'b1;
                    grant_idx   = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

    assign req_ready_o = grant;

    fpu_tag_fifo #(
        .DEPTH (DEPTH),
        .TW    (TW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant_any),
        .tag_i   (grant_idx),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_RUN;
            ptr         <= '0;
            fpu_valid_o <= 1'b0;
            fpu_a_o     <= '0;
            fpu_b_o     <= '0;
            fpu_c_o     <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            fpu_valid_o <= grant_any;
            if (grant_any) begin
                fpu_a_o <= req_a_i[grant_idx*XLEN +: XLEN];
                fpu_b_o <= req_b_i[grant_idx*XLEN +: XLEN];
                fpu_c_o <= req_c_i[grant_idx*XLEN +: XLEN];
                ptr     <= (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end

            rsp_valid_o <= '0;
            if (pop) begin
                rsp_valid_o[head] <= 1'b1;
                rsp_data_o        <= fpu_result_i;
            end

            // A result with no tag outstanding is dropped and flagged.
            if (fpu_result_valid_i && empty) err_o <= 1'b1;

            case (state)
                ST_RUN:   if (flush_i) state <= ST_DRAIN;
                ST_DRAIN: if (count == '0 && !flush_i) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: self-checking bench for fpu_arbiter (XLEN=32, NREQ=4, DEPTH=8).
module tb_fpu_arbiter;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b1;
    logic [3:0]   req_valid_i = '0;
    logic [127:0] req_a_i, req_b_i, req_c_i;
    logic [3:0]   req_ready_o;
    logic [3:0]   rsp_valid_o;
    logic [31:0]  rsp_data_o;
    logic         fpu_valid_o;
    logic [31:0]  fpu_a_o, fpu_b_o, fpu_c_o;
    logic         fpu_result_valid_i = 1'b0;
    logic [31:0]  fpu_result_i = '0;
    logic         flush_i = 1'b0;
    logic         busy_o;
    logic         err_o;

    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic [31:0] op_c [4];

    assign req_a_i = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b_i = {op_b[3], op_b[2], op_b[1], op_b[0]};
    assign req_c_i = {op_c[3], op_c[2], op_c[1], op_c[0]};

    fpu_arbiter #(
        .XLEN  (32),
        .NREQ  (4),
        .DEPTH (8)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_a_i            (req_a_i),
        .req_b_i            (req_b_i),
        .req_c_i            (req_c_i),
        .req_ready_o        (req_ready_o),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_data_o         (rsp_data_o),
        .fpu_valid_o        (fpu_valid_o),
        .fpu_a_o            (fpu_a_o),
        .fpu_b_o            (fpu_b_o),
        .fpu_c_o            (fpu_c_o),
        .fpu_result_valid_i (fpu_result_valid_i),
        .fpu_result_i       (fpu_result_i),
        .flush_i            (flush_i),
        .busy_o             (busy_o),
        .err_o              (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } iss_t;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [3:0] valid;
        logic       res;
        logic [3:0] ready;
    } vec_t;

    iss_t iss_q [$];
    rsp_t rsp_q [$];
    int   tag_q [$];
    logic exp_err = 1'b0;
    logic [31:0] rv = 32'h5EED_0000;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: inputs already set at the negedge; checks the combinational
    // grant before the edge and all registered outputs at the following negedge.
    task automatic cycle(input logic [3:0] exp_ready, input logic res, input logic [31:0] rdata);
        iss_t ie;
        rsp_t re;
        int   k;
        fpu_result_valid_i = res;
        fpu_result_i       = rdata;
        #2;
        chk("req_ready", {28'b0, req_ready_o}, {28'b0, exp_ready});
        if (res) begin
            if (tag_q.size() != 0) begin
                k       = tag_q.pop_front();
                re.vld  = 4'b0001 << k;
                re.data = rdata;
                rsp_q.push_back(re);
            end else begin
                exp_err = 1'b1;
            end
        end
        if (exp_ready != 4'b0000) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (exp_ready[i]) k = i;
            ie = '{op_a[k], op_b[k], op_c[k]};
            iss_q.push_back(ie);
            tag_q.push_back(k);
        end
        @(posedge clk);
        @(negedge clk);
        fpu_result_valid_i = 1'b0;
        if (iss_q.size() != 0) begin
            ie = iss_q.pop_front();
            chk("fpu_valid", {31'b0, fpu_valid_o}, 32'd1);
            chk("fpu_a", fpu_a_o, ie.a);
            chk("fpu_b", fpu_b_o, ie.b);
            chk("fpu_c", fpu_c_o, ie.c);
        end else begin
            chk("fpu_valid_idle", {31'b0, fpu_valid_o}, 32'd0);
        end
        if (rsp_q.size() != 0) begin
            re = rsp_q.pop_front();
            chk("rsp_valid", {28'b0, rsp_valid_o}, {28'b0, re.vld});
            chk("rsp_data", rsp_data_o, re.data);
        end else begin
            chk("rsp_valid_idle", {28'b0, rsp_valid_o}, 32'd0);
        end
        chk("err", {31'b0, err_o}, {31'b0, exp_err});
    endtask

    task automatic do_reset();
        req_valid_i        = '0;
        flush_i            = 1'b0;
        fpu_result_valid_i = 1'b0;
        fpu_result_i       = '0;
        rst_ni             = 1'b0;
        #1;
        chk("rst_fpu_valid", {31'b0, fpu_valid_o}, 32'd0);
        chk("rst_fpu_a", fpu_a_o, 32'd0);
        chk("rst_fpu_b", fpu_b_o, 32'd0);
        chk("rst_fpu_c", fpu_c_o, 32'd0);
        chk("rst_rsp_valid", {28'b0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        iss_q.delete();
        rsp_q.delete();
        tag_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic drain(input int n);
        req_valid_i = '0;
        for (int i = 0; i < n; i++) begin
            cycle(4'b0000, 1'b1, rv);
            rv = rv + 1;
        end
        chk("busy_after_drain", {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        tbl[0] = '{4'b0101, 1'b0, 4'b0001};
        tbl[1] = '{4'b0101, 1'b0, 4'b0100};
        tbl[2] = '{4'b0000, 1'b1, 4'b0000};
        tbl[3] = '{4'b1111, 1'b0, 4'b1000};
        tbl[4] = '{4'b1111, 1'b1, 4'b0001};
        tbl[5] = '{4'b1111, 1'b0, 4'b0010};
        tbl[6] = '{4'b0010, 1'b0, 4'b0010};

        for (int k = 0; k < 4; k++) begin
            op_a[k] = 32'hA000_0000 + 32'(k);
            op_b[k] = 32'hB000_0000 + 32'(k);
            op_c[k] = 32'hC000_0000 + 32'(k);
        end

        @(negedge clk);
        do_reset();

        // Table: round-robin from ptr 0, including a same-cycle grant and pop.
        for (int i = 0; i < 7; i++) begin
            req_valid_i = tbl[i].valid;
            cycle(tbl[i].ready, tbl[i].res, rv);
            if (tbl[i].res) rv = rv + 1;
        end
        drain(4);

        // All four requesters continuously valid.
        do_reset();
        req_valid_i = 4'b1111;
        cycle(4'b0001, 1'b0, 32'd0);
        cycle(4'b0010, 1'b0, 32'd0);
        cycle(4'b0100, 1'b0, 32'd0);
        cycle(4'b1000, 1'b0, 32'd0);
        cycle(4'b0001, 1'b0, 32'd0);
        drain(5);

        // Fill to DEPTH, pop at full must not grant, next cycle grants.
        do_reset();
        req_valid_i = 4'b1111;
        for (int i = 0; i < 8; i++) cycle(4'b0001 << (i % 4), 1'b0, 32'd0);
        chk("busy_full", {31'b0, busy_o}, 32'd1);
        cycle(4'b0000, 1'b0, 32'd0);
        cycle(4'b0000, 1'b1, rv);
        rv = rv + 1;
        chk("rsp_op1", {28'b0, rsp_valid_o}, 32'b0001);
        cycle(4'b0001, 1'b0, 32'd0);
        drain(8);

        // Single FMA-style op from requester 1 with a delayed result.
        do_reset();
        op_a[1] = 32'h4000_0000;
        op_b[1] = 32'h4040_0000;
        op_c[1] = 32'h3F80_0000;
        req_valid_i = 4'b0010;
        cycle(4'b0010, 1'b0, 32'd0);
        req_valid_i = 4'b0000;
        for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b0, 32'd0);
        cycle(4'b0000, 1'b1, 32'h40E0_0000);
        chk("fma_rsp_valid", {28'b0, rsp_valid_o}, 32'b0010);
        chk("fma_rsp_data", rsp_data_o, 32'h40E0_0000);

        // Flush with three ops in flight.
        do_reset();
        req_valid_i = 4'b1111;
        cycle(4'b0001, 1'b0, 32'd0);
        cycle(4'b0010, 1'b0, 32'd0);
        cycle(4'b0100, 1'b0, 32'd0);
        flush_i = 1'b1;
        cycle(4'b0000, 1'b0, 32'd0);
        flush_i = 1'b0;
        chk("busy_drain0", {31'b0, busy_o}, 32'd1);
        cycle(4'b0000, 1'b1, rv); rv = rv + 1;
        chk("busy_drain1", {31'b0, busy_o}, 32'd1);
        cycle(4'b0000, 1'b0, 32'd0);
        chk("busy_drain2", {31'b0, busy_o}, 32'd1);
        cycle(4'b0000, 1'b1, rv); rv = rv + 1;
        chk("busy_drain3", {31'b0, busy_o}, 32'd1);
        cycle(4'b0000, 1'b1, rv); rv = rv + 1;
        chk("busy_last_rsp", {31'b0, busy_o}, 32'd1);
        cycle(4'b0000, 1'b0, 32'd0);
        chk("busy_back_run", {31'b0, busy_o}, 32'd0);
        cycle(4'b1000, 1'b0, 32'd0);
        drain(1);

        // Result with nothing in flight: sticky error, no response.
        do_reset();
        cycle(4'b0000, 1'b1, 32'hDEAD_BEEF);
        chk("err_set", {31'b0, err_o}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 32'd0);
        req_valid_i = 4'b0001;
        cycle(4'b0001, 1'b0, 32'd0);
        req_valid_i = 4'b0000;
        cycle(4'b0000, 1'b1, rv); rv = rv + 1;
        chk("err_sticky", {31'b0, err_o}, 32'd1);

        // Reset with ops in flight: a stale result afterwards is an error.
        do_reset();
        req_valid_i = 4'b0011;
        cycle(4'b0001, 1'b0, 32'd0);
        cycle(4'b0010, 1'b0, 32'd0);
        do_reset();
        cycle(4'b0000, 1'b1, 32'h1234_5678);
        chk("err_stale", {31'b0, err_o}, 32'd1);
        chk("rsp_stale", {28'b0, rsp_valid_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter DEPTH, default 8, max FPU ops in flight (power of 2).
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  NREQ  per-requester operation request.
REQ-007 req_a_i, req_b_i, req_c_i  in  NREQ*XLEN each  packed operands; requester k at bits [k*XLEN +: XLEN].
REQ-008 req_ready_o  in/out: out  NREQ  one-hot accept; combinational.
REQ-009 rsp_valid_o  out  NREQ  one-hot, one-cycle result strobe.
REQ-010 rsp_data_o  out  XLEN  result, shared by all requesters, valid with rsp_valid_o.
REQ-011 fpu_valid_o  out  1  one-cycle issue strobe to FPU.
REQ-012 fpu_a_o, fpu_b_o, fpu_c_o  out  XLEN each  registered operands.
REQ-013 fpu_result_valid_i  in  1  FPU result strobe; FPU returns results in issue order.
REQ-014 fpu_result_i  in  XLEN  FPU result.
REQ-015 flush_i  in  1  stop issuing and drain.
REQ-016 busy_o  out  1  high when any op in flight or state is DRAIN.
REQ-017 err_o  out  1  sticky protocol error.

Function
REQ-018 Arbitration SHALL be round-robin: search from pointer ptr upward mod NREQ; first requester with req_valid_i high wins.
REQ-019 Grant SHALL occur only in state RUN and when in-flight count < DEPTH; a same-cycle result pop SHALL NOT enable a grant at count == DEPTH.
REQ-020 On grant to k: req_ready_o[k]=1 that cycle; ptr <= (k+1) mod NREQ; operands registered; fpu_valid_o=1 next cycle (latency 1); tag k pushed into tag FIFO.
REQ-021 Requester SHALL hold req_valid_i and operands until its req_ready_o; dropping valid without ready SHALL be tolerated (no issue).
REQ-022 fpu_result_valid_i at cycle t SHALL pop the FIFO head tag h and give rsp_valid_o[h]=1, rsp_data_o=fpu_result_i at t+1.
REQ-023 Simultaneous grant and result SHALL push and pop in the same cycle; count unchanged.
REQ-024 fpu_result_valid_i with FIFO empty SHALL set err_o, drop the result, leave rsp_valid_o at 0.
REQ-025 FSM states RUN, DRAIN. RUN->DRAIN when flush_i=1 (no grant that cycle); DRAIN->RUN when count==0 and flush_i=0.
REQ-026 In DRAIN, outstanding results SHALL still be returned per REQ-022.
REQ-027 Count and FIFO pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-028 rst_ni low SHALL immediately clear: state=RUN, ptr=0, count=0, FIFO pointers=0, fpu_valid_o=0, fpu_a/b/c_o=0, rsp_valid_o=0, rsp_data_o=0, err_o=0.
REQ-029 Reset mid-operation SHALL discard all in-flight tags; later FPU results from before reset SHALL raise err_o per REQ-024.

Structure
REQ-030 Package fpu_arb_pkg SHALL hold FSM state encoding and tag-width function/constants.
REQ-031 Tag FIFO SHALL be sub-module fpu_tag_fifo (sync, DEPTH entries, clog2(NREQ)-bit, full/empty/count outputs).

Verification
REQ-032 Reset, req_valid_i=4'b0101, ptr=0 -> grants k=0 then k=2 on consecutive cycles; fpu_valid_o pulses one cycle after each.
REQ-033 All four requesters valid continuously -> grant order 0,1,2,3,0; each req_ready_o one cycle.
REQ-034 Issue 8 ops without results -> 9th request not granted; one result returns -> grant next cycle; rsp to requester of op 1.
REQ-035 Requester 1 issues A=2.0,B=3.0,C=1.0 (0x40000000,0x40400000,0x3F800000); FPU model returns 0x40E00000 after 5 cycles -> rsp_valid_o=4'b0010, rsp_data_o=0x40E00000 one cycle later.
REQ-036 3 ops in flight, flush_i pulsed -> no grants, busy_o=1 until 3rd rsp, then RUN.
REQ-037 fpu_result_valid_i with count 0 -> err_o=1 and stays until reset; rsp_valid_o stays 0.
